jk_cmd_gen: RTL and testbench

//  Upstream driver for the jk_ff stage. Accepts queued J/K commands over a valid/ready

---
 rtl/jk_cmd_gen.sv | 201 ++++++++++++++++++++
 tb/tb_jk_cmd_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_gen.sv
// ----------------------------------------------------------------------------
// jk_cmd_gen
//   Upstream command driver for a jk_ff stage. J/K commands arrive over a
//   valid/ready handshake and wait in a small FIFO. Each command is replayed
//   on the registered j/k outputs for cmd_len+1 clocks. A reference model of
//   the flip-flop output runs alongside and is compared with the q fed back
//   from jk_ff; any divergence raises a sticky mismatch flag.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous reset, active low
//   cmd_valid   command offered
//   cmd_ready   FIFO can accept a command (not full)
//   cmd_jk      {j,k}: 00 hold, 01 reset, 10 set, 11 toggle
//   cmd_len     number of apply cycles minus one
//   j, k        registered J/K driven into jk_ff
//   q           q returned from jk_ff
//   exp_q       model of q
//   exp_valid   model is known (a set or reset has been applied)
//   mismatch    sticky: q differed from exp_q while exp_valid
//   clr_err     synchronous clear of mismatch
//   busy        a command is being applied
//   fifo_level  number of queued commands (0..DEPTH)
// ----------------------------------------------------------------------------
module jk_cmd_gen #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_jk,
   input  logic [CNT_W-1:0]         cmd_len,
   output logic                     j,
   output logic                     k,
   input  logic                     q,
   output logic                     exp_q,
   output logic                     exp_valid,
   output logic                     mismatch,
   input  logic                     clr_err,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 2 + CNT_W;
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   typedef enum logic {IDLE, APPLY} state_t;

   state_t              state;
   state_t              state_next;

   logic [EW-1:0]       mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [AW:0]         count;
   logic [CNT_W-1:0]    rem;

   logic                push;
   logic                pop;
   logic                empty;
   logic                full;
   logic [EW-1:0]       head;
   logic [1:0]          head_jk;
   logic [CNT_W-1:0]    head_len;

   assign empty    = (count == '0);
   assign full     = (count == FULL_LVL);
   assign push     = cmd_valid && !full;
   assign head     = mem[rd_ptr];
   assign head_jk  = head[EW-1:CNT_W];
   assign head_len = head[CNT_W-1:0];

   // FIFO storage needs no reset: the pointers and count define which
   // entries are live, so clearing them flushes the queue.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {cmd_jk, cmd_len};
      end
   end

   // FIFO pointers and occupancy. Popping relies on the registered count, so
   // a command pushed into an empty FIFO cannot leave before the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sequencer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and pop decision. A finishing command hands straight over to
   // the next queued one so back-to-back commands have no idle gap.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               state_next = APPLY;
            end
         end
         APPLY: begin
            if (rem == '0) begin
               if (!empty) begin
                  pop = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Status outputs derived from state and occupancy.
   always_comb begin
      busy       = (state == APPLY);
      cmd_ready  = !full;
      fifo_level = count;
   end

   // J/K drive and remaining-cycle counter. rem counts down to zero, so a
   // length of 2^CNT_W-1 yields 2^CNT_W apply cycles without wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         j   <= 1'b0;
         k   <= 1'b0;
         rem <= '0;
      end else if (pop) begin
         {j, k} <= head_jk;
         rem    <= head_len;
      end else if (state == APPLY) begin
         if (rem != '0) begin
            rem <= rem - 1'b1;
         end else begin
            j <= 1'b0;
            k <= 1'b0;
         end
      end
   end

   // Reference model of jk_ff. It reacts to the same registered j/k at the
   // same edge as the real flop, so exp_q and q line up with no skew.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q     <= 1'b0;
         exp_valid <= 1'b0;
      end else begin
         case ({j, k})
            2'b01: begin
               exp_q     <= 1'b0;
               exp_valid <= 1'b1;
            end
            2'b10: begin
               exp_q     <= 1'b1;
               exp_valid <= 1'b1;
            end
            2'b11:   exp_q <= ~exp_q;
            default: exp_q <= exp_q;
         endcase
      end
   end

   // Sticky divergence flag. A fresh mismatch takes priority over a clear
   // arriving at the same edge so no error is ever lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatch <= 1'b0;
      end else if (exp_valid && (q != exp_q)) begin
         mismatch <= 1'b1;
      end else if (clr_err) begin
         mismatch <= 1'b0;
      end
   end

endmodule

// File: tb/tb_jk_cmd_gen.sv
// ----------------------------------------------------------------------------
// tb_jk_cmd_gen
//   Self-checking bench for jk_cmd_gen. A behavioural jk_ff closes the q loop;
//   a fault switch can tie q low. Per-cycle expectations are hand computed.
// ----------------------------------------------------------------------------
module tb_jk_cmd_gen;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_jk;
   logic [3:0] cmd_len;
   logic       j;
   logic       k;
   logic       q;
   logic       exp_q;
   logic       exp_valid;
   logic       mismatch;
   logic       clr_err;
   logic       busy;
   logic [2:0] fifo_level;

   logic       q_ff;
   logic       fault;

   int errors;
   int checks;

   typedef struct {
      logic       valid;
      logic [1:0] jk;
      logic [3:0] len;
      logic       ej;
      logic       ek;
      logic       eq;
      logic       ev;
      logic       eb;
      logic [2:0] el;
   } vec_t;

   vec_t vecs [15];

   jk_cmd_gen #(.DEPTH(4), .CNT_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_jk     (cmd_jk),
      .cmd_len    (cmd_len),
      .j          (j),
      .k          (k),
      .q          (q),
      .exp_q      (exp_q),
      .exp_valid  (exp_valid),
      .mismatch   (mismatch),
      .clr_err    (clr_err),
      .busy       (busy),
      .fifo_level (fifo_level)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural jk_ff with no reset; the fault switch ties its output low.
   initial q_ff = 1'b0;
   always @(posedge clk) begin
      case ({j, k})
         2'b01:   q_ff <= 1'b0;
         2'b10:   q_ff <= 1'b1;
         2'b11:   q_ff <= ~q_ff;
         default: q_ff <= q_ff;
      endcase
   end
   assign q = fault ? 1'b0 : q_ff;

   // Drive one cycle of inputs, then sample just after the next rising edge.
   task automatic applyStimulus(input logic v, input logic [1:0] jk,
                                input logic [3:0] len, input logic clr);
      cmd_valid = v;
      cmd_jk    = jk;
      cmd_len   = len;
      clr_err   = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] act,
                              input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      fault     = 1'b0;
      cmd_valid = 1'b0;
      cmd_jk    = 2'b00;
      cmd_len   = 4'd0;
      clr_err   = 1'b0;
      rst_n     = 1'b0;

      //                 valid jk     len   j     k     eq    ev    busy  level
      // set(len0) then reset(len2)
      vecs[0]  = '{1'b1, 2'b10, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
      vecs[1]  = '{1'b1, 2'b01, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
      vecs[2]  = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0};
      vecs[3]  = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0};
      vecs[4]  = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0};
      vecs[5]  = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
      vecs[6]  = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
      // set(len0) then toggle(len3)
      vecs[7]  = '{1'b1, 2'b10, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1};
      vecs[8]  = '{1'b1, 2'b11, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1};
      vecs[9]  = '{1'b0, 2'b00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0};
      vecs[10] = '{1'b0, 2'b00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0};
      vecs[11] = '{1'b0, 2'b00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0};
      vecs[12] = '{1'b0, 2'b00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0};
      vecs[13] = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
      vecs[14] = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};

      // Reset values while rst_n is held low.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst.j", 8'(j), 8'd0);
      checkOutput("rst.k", 8'(k), 8'd0);
      checkOutput("rst.exp_valid", 8'(exp_valid), 8'd0);
      checkOutput("rst.mismatch", 8'(mismatch), 8'd0);
      checkOutput("rst.level", 8'(fifo_level), 8'd0);
      checkOutput("rst.ready", 8'(cmd_ready), 8'd1);
      checkOutput("rst.busy", 8'(busy), 8'd0);
      rst_n = 1'b1;

      // Table-driven sequences: set/reset and set/toggle chains.
      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].jk, vecs[i].len, 1'b0);
         checkOutput($sformatf("v%0d.j", i), 8'(j), 8'(vecs[i].ej));
         checkOutput($sformatf("v%0d.k", i), 8'(k), 8'(vecs[i].ek));
         checkOutput($sformatf("v%0d.exp_q", i), 8'(exp_q), 8'(vecs[i].eq));
         checkOutput($sformatf("v%0d.exp_valid", i), 8'(exp_valid), 8'(vecs[i].ev));
         checkOutput($sformatf("v%0d.busy", i), 8'(busy), 8'(vecs[i].eb));
         checkOutput($sformatf("v%0d.level", i), 8'(fifo_level), 8'(vecs[i].el));
         checkOutput($sformatf("v%0d.mismatch", i), 8'(mismatch), 8'd0);
      end

      // FIFO fill: hold(len15) then four more, a sixth held until a pop.
      applyStimulus(1'b1, 2'b00, 4'd15, 1'b0);
      applyStimulus(1'b1, 2'b10, 4'd1, 1'b0);
      applyStimulus(1'b1, 2'b01, 4'd0, 1'b0);
      applyStimulus(1'b1, 2'b11, 4'd0, 1'b0);
      applyStimulus(1'b1, 2'b10, 4'd0, 1'b0);
      checkOutput("full.level", 8'(fifo_level), 8'd4);
      checkOutput("full.ready", 8'(cmd_ready), 8'd0);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 2'b01, 4'd0, 1'b0);
      end
      checkOutput("hold15.level", 8'(fifo_level), 8'd4);
      checkOutput("hold15.jk", 8'({j, k}), 8'd0);
      checkOutput("hold15.busy", 8'(busy), 8'd1);
      applyStimulus(1'b1, 2'b01, 4'd0, 1'b0);
      checkOutput("pop1.jk", 8'({j, k}), 8'd2);
      checkOutput("pop1.level", 8'(fifo_level), 8'd3);
      checkOutput("pop1.ready", 8'(cmd_ready), 8'd1);
      applyStimulus(1'b1, 2'b01, 4'd0, 1'b0);
      checkOutput("push6.level", 8'(fifo_level), 8'd4);
      checkOutput("push6.jk", 8'({j, k}), 8'd2);
      applyStimulus(1'b0, 2'b00, 4'd0, 1'b0);
      checkOutput("drain3.jk", 8'({j, k}), 8'd1);
      checkOutput("drain3.level", 8'(fifo_level), 8'd3);
      applyStimulus(1'b0, 2'b00, 4'd0, 1'b0);
      checkOutput("drain4.jk", 8'({j, k}), 8'd3);
      applyStimulus(1'b0, 2'b00, 4'd0, 1'b0);
      checkOutput("drain5.jk", 8'({j, k}), 8'd2);
      applyStimulus(1'b0, 2'b00, 4'd0, 1'b0);
      checkOutput("drain6.jk", 8'({j, k}), 8'd1);
      checkOutput("drain6.level", 8'(fifo_level), 8'd0);
      applyStimulus(1'b0, 2'b00, 4'd0, 1'b0);
      checkOutput("drained.jk", 8'({j, k}), 8'd0);
      checkOutput("drained.busy", 8'(busy), 8'd0);
      checkOutput("drained.exp_q", 8'(exp_q), 8'd0);
      checkOutput("drained.mismatch", 8'(mismatch), 8'd0);

      // q tied low as a fault, then cleared; set wins over clear.
      fault = 1'b1;
      applyStimulus(1'b1, 2'b10, 4'd0, 1'b0);
      applyStimulus(1'b0, 2'b00, 4'd0, 1'b0);
      applyStimulus(1'b0, 2'b00, 4'd0, 1'b0);
      checkOutput("fault.exp_q", 8'(exp_q), 8'd1);
      checkOutput("fault.mismatch_pre", 8'(mismatch), 8'd0);
      applyStimulus(1'b0, 2'b00, 4'd0, 1'b0);
      checkOutput("fault.mismatch_set", 8'(mismatch), 8'd1);
      applyStimulus(1'b0, 2'b00, 4'd0, 1'b0);
      checkOutput("fault.mismatch_sticky", 8'(mismatch), 8'd1);
      fault = 1'b0;
      applyStimulus(1'b0, 2'b00, 4'd0, 1'b1);
      checkOutput("clr.mismatch", 8'(mismatch), 8'd0);
      fault = 1'b1;
      applyStimulus(1'b0, 2'b00, 4'd0, 1'b1);
      checkOutput("setwins.mismatch", 8'(mismatch), 8'd1);
      fault = 1'b0;
      applyStimulus(1'b0, 2'b00, 4'd0, 1'b1);
      checkOutput("clr2.mismatch", 8'(mismatch), 8'd0);
      applyStimulus(1'b0, 2'b00, 4'd0, 1'b0);
      checkOutput("clr2.hold", 8'(mismatch), 8'd0);

      // Reset during toggle(len15) with two commands queued.
      applyStimulus(1'b1, 2'b11, 4'd15, 1'b0);
      applyStimulus(1'b1, 2'b10, 4'd0, 1'b0);
      applyStimulus(1'b1, 2'b01, 4'd0, 1'b0);
      checkOutput("mid.level", 8'(fifo_level), 8'd2);
      checkOutput("mid.jk", 8'({j, k}), 8'd3);
      applyStimulus(1'b0, 2'b00, 4'd0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst.jk", 8'({j, k}), 8'd0);
      checkOutput("arst.level", 8'(fifo_level), 8'd0);
      checkOutput("arst.busy", 8'(busy), 8'd0);
      checkOutput("arst.exp_valid", 8'(exp_valid), 8'd0);
      checkOutput("arst.ready", 8'(cmd_ready), 8'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 2'b00, 4'd0, 1'b0);
         checkOutput($sformatf("post%0d.jk", i), 8'({j, k}), 8'd0);
         checkOutput($sformatf("post%0d.busy", i), 8'(busy), 8'd0);
      end
      checkOutput("post.level", 8'(fifo_level), 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
